// File: rtl/debounced_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : debounced_edge_detector
// Brief    : N-channel synchroniser + debouncer with registered edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounced_edge_detector #(
  parameter int N            = 4,
  parameter int BOUNCE_TICKS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] signal,
  input  logic [1:0]   mode,
  output logic [N-1:0] level,
  output logic [N-1:0] rising,
  output logic [N-1:0] falling,
  output logic [N-1:0] edge_detected,
  output logic         any_edge
);

  localparam int            CW        = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BOUNCE_TICKS - 1);
  localparam logic [1:0]    MODE_RISE = 2'b00;
  localparam logic [1:0]    MODE_FALL = 2'b01;
  localparam logic [1:0]    MODE_BOTH = 2'b10;

  logic [N-1:0]  s1_q, s1_d;
  logic [N-1:0]  s2_q, s2_d;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  rising_q, rising_d;
  logic [N-1:0]  falling_q, falling_d;
  logic [N-1:0]  edge_q, edge_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  always_comb begin
    s1_d      = signal;
    s2_d      = s1_q;
    level_d   = level_q;
    rising_d  = '0;
    falling_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ena) begin
        if (s2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // Mismatch has now persisted BOUNCE_TICKS enabled cycles: accept it.
          level_d[i]   = s2_q[i];
          cnt_d[i]     = '0;
          rising_d[i]  = s2_q[i];
          falling_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    case (mode)
      MODE_RISE: edge_d = rising_d;
      MODE_FALL: edge_d = falling_d;
      MODE_BOTH: edge_d = rising_d | falling_d;
      default:   edge_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      rising_q  <= '0;
      falling_q <= '0;
      edge_q    <= '0;
      cnt_q     <= '{default: '0};
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      rising_q  <= rising_d;
      falling_q <= falling_d;
      edge_q    <= edge_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level         = level_q;
  assign rising        = rising_q;
  assign falling       = falling_q;
  assign edge_detected = edge_q;
  assign any_edge      = |edge_q;

endmodule
`default_nettype wire

// File: tb/tb_debounced_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounced_edge_detector
// Brief    : Directed self-checking bench for debounced_edge_detector (N=4, 4 ticks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounced_edge_detector;

  localparam int N  = 4;
  localparam int BT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b0;
  logic [N-1:0] signal = '0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] level, rising, falling, edge_detected;
  logic         any_edge;

  int n_checks = 0;
  int n_passed = 0;

  debounced_edge_detector #(.N(N), .BOUNCE_TICKS(BT)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .signal        (signal),
    .mode          (mode),
    .level         (level),
    .rising        (rising),
    .falling       (falling),
    .edge_detected (edge_detected),
    .any_edge      (any_edge)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Channel 2 high for 10 sampled edges, then low; rise expected at step 6, fall at 16.
  task automatic run_ch2(output int n_r, output int n_f, output int n_e,
                         output int first_e, output int last_e);
    n_r = 0; n_f = 0; n_e = 0; first_e = -1; last_e = -1;
    signal[2] = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      step();
      if (rising[2])  n_r++;
      if (falling[2]) n_f++;
      if (edge_detected[2]) begin
        n_e++;
        if (first_e < 0) first_e = t;
        last_e = t;
      end
      if (t == 10) signal[2] = 1'b0;
    end
  endtask

  int   n_r, n_f, n_e, first_e, last_e, cnt;
  logic seen;

  initial begin
    // Reset held with all inputs high
    rst = 1'b0; ena = 1'b1; mode = 2'b00; signal = 4'hF;
    step(5);
    check("rst_level",   32'(level),         32'h0);
    check("rst_rising",  32'(rising),        32'h0);
    check("rst_falling", 32'(falling),       32'h0);
    check("rst_edge",    32'(edge_detected), 32'h0);
    check("rst_any",     32'(any_edge),      32'h0);
    signal = '0;
    step(1);
    rst = 1'b1;
    step(3);
    check("idle_level", 32'(level), 32'h0);

    // Clean rise on channel 0: accepted at posedge k+5
    signal[0] = 1'b1;
    step(5);
    check("rise_k4_level",  32'(level),  32'h0);
    check("rise_k4_rising", 32'(rising), 32'h0);
    step(1);
    check("rise_k5_level",   32'(level),         32'h1);
    check("rise_k5_rising",  32'(rising),        32'h1);
    check("rise_k5_edge",    32'(edge_detected), 32'h1);
    check("rise_k5_any",     32'(any_edge),      32'h1);
    check("rise_k5_falling", 32'(falling),       32'h0);
    step(1);
    check("rise_k6_rising", 32'(rising),   32'h0);
    check("rise_k6_any",    32'(any_edge), 32'h0);
    check("rise_k6_level",  32'(level),    32'h1);

    // Three-cycle glitch on channel 1 must be rejected
    signal[1] = 1'b1;
    step(3);
    signal[1] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      step();
      seen |= rising[1] | falling[1];
    end
    check("glitch_pulse", 32'(seen),  32'h0);
    check("glitch_level", 32'(level), 32'h1);
    signal[1] = 1'b1;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (rising[1]) cnt++;
    end
    check("held_one_pulse", 32'(cnt),   32'h1);
    check("held_level",     32'(level), 32'h3);

    // Mode selection on channel 2
    mode = 2'b10;
    run_ch2(n_r, n_f, n_e, first_e, last_e);
    check("both_edges",  32'(n_e),     32'd2);
    check("both_first",  32'(first_e), 32'd6);
    check("both_second", 32'(last_e),  32'd16);
    mode = 2'b11;
    run_ch2(n_r, n_f, n_e, first_e, last_e);
    check("none_rising",  32'(n_r), 32'd1);
    check("none_falling", 32'(n_f), 32'd1);
    check("none_edges",   32'(n_e), 32'd0);
    mode = 2'b01;
    run_ch2(n_r, n_f, n_e, first_e, last_e);
    check("fall_edges", 32'(n_e),     32'd1);
    check("fall_at",    32'(first_e), 32'd16);
    check("modes_level", 32'(level), 32'h3);

    // Enable freeze on channel 3 after two counted cycles
    mode = 2'b00;
    signal[3] = 1'b1;
    step(4);
    ena = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      step();
      seen |= |(rising | falling | edge_detected);
    end
    check("freeze_pulse", 32'(seen),  32'h0);
    check("freeze_level", 32'(level), 32'h3);
    ena = 1'b1;
    step(1);
    check("thaw1_level",  32'(level),  32'h3);
    check("thaw1_rising", 32'(rising), 32'h0);
    step(1);
    check("thaw2_level",  32'(level),         32'hB);
    check("thaw2_rising", 32'(rising),        32'h8);
    check("thaw2_edge",   32'(edge_detected), 32'h8);

    // Asynchronous reset between clock edges
    step(1);
    #3 rst = 1'b0;
    #1;
    check("async_level", 32'(level),    32'h0);
    check("async_any",   32'(any_edge), 32'h0);

    // Reset in the middle of a count discards it
    signal = 4'hF;
    step(2);
    rst = 1'b1;
    step(4);
    rst = 1'b0;
    step(2);
    check("midrst_level", 32'(level), 32'h0);
    rst = 1'b1;
    step(5);
    check("rerise_r4_rising", 32'(rising), 32'h0);
    step(1);
    check("rerise_r5_rising", 32'(rising),   32'hF);
    check("rerise_r5_level",  32'(level),    32'hF);
    check("rerise_r5_any",    32'(any_edge), 32'h1);
    step(1);
    check("rerise_r6_rising", 32'(rising), 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debounced_edge_detector.md
# debounced_edge_detector

Multi-channel, parametrised successor to the single-bit edge detector used by the etch-a-sketch input path. Each of `N` asynchronous inputs (buttons, encoder lines) is synchronised, debounced by a per-channel stability counter, and converted to a clean level plus registered one-cycle rising/falling pulses. A run-time mode selects which edges appear on `edge_detected`. The block sits between the board pins and the drawing-control FSM.

## Interface

Parameters:
- `N`, 4, number of independent channels (≥1).
- `BOUNCE_TICKS`, 4, consecutive enabled cycles a new synchronised value must persist before it is accepted (≥1).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserted when 0).
- `ena`  input  1  global enable; when 0, counters and levels freeze.
- `signal`  input  N  raw asynchronous inputs.
- `mode`  input  2  edge select: 00 rising, 01 falling, 10 both, 11 none.
- `level`  output  N  debounced level per channel.
- `rising`  output  N  one-cycle pulse on accepted 0→1 transition.
- `falling`  output  N  one-cycle pulse on accepted 1→0 transition.
- `edge_detected`  output  N  `rising`/`falling` filtered by `mode`, registered.
- `any_edge`  output  1  OR-reduction of `edge_detected` (combinational from registers).

## Operation

- Per channel: two-flop synchroniser `s1`→`s2`, counter `cnt` of width `$clog2(BOUNCE_TICKS+1)`, registered `level`.
- On each posedge with `ena`=1, per channel:
  - `s2 == level`: `cnt` ← 0, no pulse.
  - `s2 != level` and `cnt < BOUNCE_TICKS-1`: `cnt` ← `cnt`+1, no pulse.
  - `s2 != level` and `cnt == BOUNCE_TICKS-1`: `level` ← `s2`, `cnt` ← 0, pulse `rising` (if `s2`=1) or `falling` (if `s2`=0).
- `edge_detected[i]` is registered on the same edge as the pulse, using `mode` sampled at that edge: 00→`rising`, 01→`falling`, 10→either, 11→0.
- `ena`=0: synchronisers keep sampling; `cnt`, `level` hold; `rising`, `falling`, `edge_detected` are 0 that cycle.
- Channels fully independent; simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Glitch (mismatch lasting fewer than `BOUNCE_TICKS` enabled cycles) clears `cnt` when `s2` returns to `level`; no level change, no pulse.
- `mode` change takes effect on the next accepted transition; never retroactively creates or removes a pulse already registered.

## Timing

- Reset (`rst`=0, immediate, asynchronous): `s1`, `s2`, `cnt`, `level`, `rising`, `falling`, `edge_detected` all 0; `any_edge` 0.
- Latency: `signal[i]` stable before posedge k (with `ena`=1 throughout) → `s2` valid after posedge k+1 → `level[i]` and pulse update at posedge k+1+`BOUNCE_TICKS`.
- Pulses high exactly one clock cycle; a level cannot change again sooner than `BOUNCE_TICKS` cycles after the previous change, so pulses on one channel are ≥`BOUNCE_TICKS` cycles apart.
- Reset mid-count discards the count; after release, an input held high re-debounces from `level`=0 and produces a rising pulse at release-edge + 1 + `BOUNCE_TICKS`.
- Reset release is synchronous to `clk` by the integrator; block makes no assumption beyond that.

## Test plan

- Reset: hold `rst`=0 with `signal`=4'hF, toggle clock 5 cycles → all outputs 0; assert `rst`=0 asynchronously mid-cycle → outputs clear without a clock edge.
- Clean rise, N=4, BOUNCE_TICKS=4, mode=00: `signal[0]` 0→1 before posedge k, held → `level[0]`=1 and `rising[0]`=`edge_detected[0]`=`any_edge`=1 at posedge k+5, low at k+6; other channels stay 0.
- Bounce rejection: `signal[1]` high for 3 cycles then low → `level[1]`=0, no pulses ever; then high for 4+ cycles → single rising pulse.
- Mode both (10): `signal[2]` high 10 cycles then low 10 cycles → two `edge_detected[2]` pulses 10 cycles apart; same stimulus with mode=11 → `rising`/`falling` pulse, `edge_detected` stays 0; mode=01 → only the falling pulse on `edge_detected`.
- Enable freeze: `signal[3]` rises, `ena`=0 for 6 cycles after 2 counted cycles → no change; `ena`=1 → pulse after 2 more enabled cycles.
- Reset mid-count: `signal`=4'hF, assert `rst` after 2 counted cycles, release at edge r → all four `rising` pulses together at posedge r+5.
